// File: rtl/contador_pkg.sv
// Shared types and defaults for the multi-channel FIFO pop counter.
package contador_pkg;

  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 5;
  localparam int unsigned IDX_W_DEF = 2;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_SINGLE = 2'd1,
    S_SWEEP  = 2'd2
  } state_t;

  // Terminal count for a counter of the given width.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/contador_if.sv
// Host-side read port of the pop counter bank: request in, registered response out.
interface contador_if #(
    parameter int unsigned CNT_W = 5,
    parameter int unsigned IDX_W = 2
);
    logic             idle;
    logic             req;
    logic             req_all;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             valid_contador;
    logic [CNT_W-1:0] contador_out;
    logic [IDX_W-1:0] contador_idx;
    logic             ovf_out;
    logic             err_out;

    modport master (
        output idle, req, req_all, idx,
        input  busy, valid_contador, contador_out, contador_idx, ovf_out, err_out
    );

    modport slave (
        input  idle, req, req_all, idx,
        output busy, valid_contador, contador_out, contador_idx, ovf_out, err_out
    );
endinterface

// File: rtl/contador_ch.sv
// One channel: pop counter with sticky overflow flag, wrap or saturate at terminal count.
module contador_ch
    import contador_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            // A pop landing on the clearing edge is kept, not lost.
            cnt <= inc ? CNT_W'(1) : '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (cnt == CMAX) begin
                ovf <= 1'b1;
                if (!SATURATE) cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/contador_multi.sv
// N_CH pop counters with single/sweep readout; CONTADOR_CLR_ON_READ_EN makes reads destructive.
module contador_multi
    import contador_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter bit          SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] pop,
    input  logic [N_CH-1:0] empty,
    contador_if.slave       bus
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

    logic [CNT_W-1:0] cnt [N_CH];
    logic [N_CH-1:0]  ovf;
    logic [N_CH-1:0]  clr;

    state_t           state;
    logic [IDX_W-1:0] ptr;

    logic             rd_en;
    logic [IDX_W-1:0] rd_ch;
    logic             rd_ok;
    logic [CNT_W-1:0] rd_val;
    logic             rd_ovf;

    logic             busy_r;
    logic             valid_r;
    logic [CNT_W-1:0] out_r;
    logic [IDX_W-1:0] cidx_r;
    logic             ovf_r;
    logic             err_r;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        contador_ch #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .inc   (pop[g] & ~empty[g]),
            .clr   (clr[g]),
            .cnt   (cnt[g]),
            .ovf   (ovf[g])
        );
    end

    // The channel read on this edge is chosen combinationally so the response
    // register captures the pre-increment value on the same edge.
    always_comb begin
        rd_en = 1'b0;
        rd_ch = '0;
        unique case (state)
            S_WAIT: begin
                if (bus.idle && bus.req_all) begin
                    rd_en = 1'b1;
                end else if (bus.idle && bus.req) begin
                    rd_en = 1'b1;
                    rd_ch = bus.idx;
                end
            end
            S_SWEEP: begin
                if (ptr != LAST) begin
                    rd_en = 1'b1;
                    rd_ch = ptr + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_ok  = (32'(rd_ch) < N_CH);
        rd_val = '0;
        rd_ovf = 1'b0;
        clr    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (rd_ch == IDX_W'(i)) begin
                rd_val = cnt[i];
                rd_ovf = ovf[i];
`ifdef CONTADOR_CLR_ON_READ_EN
                clr[i] = rd_en;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_WAIT;
            ptr     <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            out_r   <= '0;
            cidx_r  <= '0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            valid_r <= rd_en;
            if (rd_en) begin
                out_r  <= rd_val;
                cidx_r <= rd_ch;
                ovf_r  <= rd_ovf;
                err_r  <= ~rd_ok;
            end
            unique case (state)
                S_WAIT: begin
                    if (bus.idle && bus.req_all) begin
                        state  <= S_SWEEP;
                        ptr    <= '0;
                        busy_r <= 1'b1;
                    end else if (bus.idle && bus.req) begin
                        state <= S_SINGLE;
                    end
                end
                S_SINGLE: state <= S_WAIT;
                S_SWEEP: begin
                    if (ptr == LAST) begin
                        state  <= S_WAIT;
                        busy_r <= 1'b0;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign bus.busy           = busy_r;
    assign bus.valid_contador = valid_r;
    assign bus.contador_out   = out_r;
    assign bus.contador_idx   = cidx_r;
    assign bus.ovf_out        = ovf_r;
    assign bus.err_out        = err_r;

endmodule
